fetch_stage: RTL



---
 rtl/mips_pkg.sv | 23 ++
 rtl/fetch_prefetch_fifo.sv | 89 ++++++++
 rtl/fetch_stage.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
//   Shared constants and types for the MIPS pipeline front end.
//   - NOP_INSTR        : all-zero word (sll $0,$0,0), used as the bubble.
//   - DEFAULT_RESET_PC : boot address of the program memory.
//   - fetch_entry_t    : one fetched word paired with its PC+4.
//   - align_word()     : clears the byte-offset bits of an address.
// ----------------------------------------------------------------------------
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_4;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_prefetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_prefetch_fifo
//   Small synchronous FIFO of fetch_entry_t that soaks up fetched words while
//   decode is stalled. DEPTH must be a power of two and at least 2, so the
//   read/write pointers wrap for free; an extra count bit separates full
//   from empty.
//
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   push       : write din at the tail
//   pop        : drop the head entry
//   flush      : discard all entries; wins over push and pop
//   din        : entry to write
//   full       : DEPTH entries held
//   empty      : no entries held
//   head       : oldest entry (combinational read)
// ----------------------------------------------------------------------------
module fetch_prefetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A push into a full FIFO is only accepted when the head leaves in the
  // same cycle, which keeps the count unchanged.
  always_comb begin
    do_push = push && !flush && (!full || pop);
    do_pop  = pop  && !flush && !empty;
  end

  // Pointer and occupancy bookkeeping; flush simply rewinds everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Entry storage carries no reset: stale data is never observable because
  // the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch front end of the 5-stage MIPS pipeline. Owns the PC,
//   drives the program-memory address combinationally, buffers fetched words
//   in a prefetch FIFO while decode stalls, and presents a registered
//   instruction plus PC+4 to decode. A redirect from execute flushes all
//   in-flight words and restarts fetch at the (word-aligned) target.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   Adds stall_cycles_o, a saturating count of cycles where decode stalled
//   on a valid instruction with no redirect pending.
//
// Ports:
//   clk, reset        : clock and asynchronous active-high reset
//   stall_i           : decode cannot accept a new instruction
//   redirect_valid_i  : taken branch / jump resolved in execute
//   redirect_pc_i     : redirect target
//   imem_addr_o       : program-memory address (equals the PC)
//   imem_instr_i      : word at imem_addr_o, same cycle
//   instr_D_o         : registered instruction to decode
//   pc_4_D_o          : registered PC+4 of instr_D_o
//   valid_D_o         : decode outputs hold a real instruction
//   stall_cycles_o    : (FETCH_PERF_CNT_EN only) stall cycle counter
// ----------------------------------------------------------------------------
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] instr_D_o,
  output logic [31:0] pc_4_D_o,
  output logic        valid_D_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles_o
`endif
);

  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic         advance;
  logic         fetch_en;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_push;
  logic         fifo_pop;
  fetch_entry_t fifo_head;
  fetch_entry_t fetch_entry;
  logic [31:0]  instr_d;
  logic [31:0]  pc_4_d;
  logic         valid_d;

  assign imem_addr_o = pc_q;

  // A stall against an empty output register is treated as bubble fill,
  // so decode never waits on a slot that holds nothing.
  assign advance  = !stall_i || !valid_D_o;
  assign fetch_en = !(fifo_full && !advance);

  assign fetch_entry = '{instr: imem_instr_i, pc_4: pc_q + 32'd4};

  // Words go into the FIFO unless they can bypass straight to the output
  // register; the head leaves whenever decode advances and something is
  // buffered. A redirect suppresses both, and flush wipes the contents.
  always_comb begin
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (!redirect_valid_i) begin
      fifo_push = fetch_en && !(advance && fifo_empty);
      fifo_pop  = advance && !fifo_empty;
    end
  end

  fetch_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_prefetch (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid_i),
    .din   (fetch_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Next PC and next decode-register contents. Redirect overrides stall and
  // does not fetch from the old PC; otherwise the output register takes the
  // oldest available word (FIFO head first, else the word being fetched).
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_D_o;
    pc_4_d  = pc_4_D_o;
    valid_d = valid_D_o;
    if (redirect_valid_i) begin
      pc_d    = align_word(redirect_pc_i);
      instr_d = NOP_INSTR;
      pc_4_d  = 32'h0;
      valid_d = 1'b0;
    end else begin
      if (fetch_en) begin
        pc_d = pc_q + 32'd4;
      end
      if (advance) begin
        valid_d = 1'b1;
        if (fifo_empty) begin
          instr_d = fetch_entry.instr;
          pc_4_d  = fetch_entry.pc_4;
        end else begin
          instr_d = fifo_head.instr;
          pc_4_d  = fifo_head.pc_4;
        end
      end
    end
  end

  // PC and decode-stage register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      instr_D_o <= NOP_INSTR;
      pc_4_D_o  <= 32'h0;
      valid_D_o <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_D_o <= instr_d;
      pc_4_D_o  <= pc_4_d;
      valid_D_o <= valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Counts cycles where decode holds a real instruction it cannot take;
  // sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_o <= 32'h0;
    end else if (stall_i && valid_D_o && !redirect_valid_i &&
                 (stall_cycles_o != 32'hFFFF_FFFF)) begin
      stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule
